// File: rtl/be_to_le_bridge_pkg.sv
// be_to_le_bridge_pkg
//   Shared types and helpers for the big-endian to little-endian AXI4-Stream
//   bridge.
//   Contents:
//     pkt_state_t   packet framing state (WAIT_SOP / IN_PKT)
//     KEEP_MAX_W    widest tkeep the helpers accept
//     is_low_mask   true when a keep vector is 2^k-1 with k >= 1
package be_to_le_bridge_pkg;

  typedef enum logic [0:0] {
    WAIT_SOP = 1'b0,
    IN_PKT   = 1'b1
  } pkt_state_t;

  localparam int KEEP_MAX_W = 128;

  // A contiguous run of ones starting at bit 0 has no bit in common with
  // itself plus one. Zero-extension keeps this property, so narrower keeps
  // are widened to KEEP_MAX_W before the call.
  function automatic logic is_low_mask(input logic [KEEP_MAX_W-1:0] k);
    return (k != '0) && ((k & (k + KEEP_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/be_to_le_bridge_axis_skid_slice.sv
// axis_skid_slice
//   Generic 2-entry register slice: an output register (OR) plus a skid
//   register (SK). Both s_ready and the outputs come straight from flops.
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     s_data/s_valid    upstream payload and valid
//     s_ready           upstream ready (registered, equals !SK.valid)
//     m_data/m_valid    downstream payload and valid
//     m_ready           downstream ready
module axis_skid_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] or_data;
  logic [W-1:0] sk_data;
  logic         or_valid;
  logic         sk_valid;
  logic         ready_q;
  logic         accept;
  logic         or_free;
  logic         sk_load;
  logic         sk_valid_d;

  assign accept  = s_valid & ready_q;
  // OR can take a new beat when empty or when its current beat drains now.
  assign or_free = !or_valid | m_ready;

  // A beat lands in SK only when OR is blocked, or when SK still owns the
  // next OR slot (keeps ordering if a beat ever arrives while SK is full).
  assign sk_load    = accept & (!or_free | sk_valid);
  assign sk_valid_d = sk_load | (sk_valid & !or_free);

  always_ff @(posedge clk) begin
    if (reset) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
      ready_q  <= 1'b0;
      or_data  <= '0;
      sk_data  <= '0;
    end else begin
      if (or_free) begin
        if (sk_valid) begin
          or_data  <= sk_data;
          or_valid <= 1'b1;
        end else begin
          or_valid <= accept;
          if (accept) or_data <= s_data;
        end
      end
      if (sk_load) sk_data <= s_data;
      sk_valid <= sk_valid_d;
      ready_q  <= !sk_valid_d;
    end
  end

  assign s_ready = ready_q;
  assign m_data  = or_data;
  assign m_valid = or_valid;

endmodule

// File: rtl/be_to_le_bridge.sv
// be_to_le_bridge
//   Converts a big-endian AXI4-Stream (byte 0 in the top byte lane, tkeep
//   MSB-aligned) into a little-endian one (tkeep LSB-aligned). Output is
//   fully registered through a 2-entry skid slice. Also checks tkeep
//   framing and counts accepted packets.
//   Ports:
//     clk, reset               clock, synchronous active-high reset
//     s_axis_*                 big-endian input stream
//     m_axis_*                 little-endian output stream
//     pkt_count                accepted tlast beats, wraps at 2^C_CNT_WIDTH
//     keep_err                 1-cycle pulse after a beat with bad tkeep
module be_to_le_bridge
  import be_to_le_bridge_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [C_CNT_WIDTH-1:0]          pkt_count,
  output logic                            keep_err
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int NB = C_AXIS_DATA_WIDTH / 8;
  localparam int TW = C_AXIS_TUSER_WIDTH;
  localparam int PW = TW + 1 + NB + DW;

  logic [DW-1:0]      tdata_le;
  logic [NB-1:0]      tkeep_le;
  logic [PW-1:0]      payload_in;
  logic [PW-1:0]      payload_out;
  logic               accept;
  pkt_state_t         state_q;
  pkt_state_t         state_d;
  logic               keep_bad;
  logic               pkt_done;
  logic               keep_err_q;
  logic [C_CNT_WIDTH-1:0] pkt_count_q;

  // Byte lane i of the output takes lane NB-1-i of the input.
  always_comb begin
    tdata_le = '0;
    tkeep_le = '0;
    for (int i = 0; i < NB; i++) begin
      tdata_le[8*i +: 8] = s_axis_tdata[8*(NB-1-i) +: 8];
      tkeep_le[i]        = s_axis_tkeep[NB-1-i];
    end
  end

  assign payload_in = {s_axis_tuser, s_axis_tlast, tkeep_le, tdata_le};

  axis_skid_slice #(
    .W (PW)
  ) u_slice (
    .clk     (clk),
    .reset   (reset),
    .s_data  (payload_in),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .m_data  (payload_out),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = payload_out;

  assign accept = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= WAIT_SOP;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        WAIT_SOP: if (!s_axis_tlast) state_d = IN_PKT;
        IN_PKT:   if (s_axis_tlast)  state_d = WAIT_SOP;
        default:  state_d = WAIT_SOP;
      endcase
    end
  end

  // Framing is judged on the converted (LSB-aligned) keep.
  always_comb begin
    keep_bad = 1'b0;
    pkt_done = 1'b0;
    if (accept) begin
      pkt_done = s_axis_tlast;
      if (s_axis_tlast) keep_bad = !is_low_mask(KEEP_MAX_W'(tkeep_le));
      else              keep_bad = (tkeep_le != '1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keep_err_q  <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      keep_err_q <= keep_bad;
      if (pkt_done) pkt_count_q <= pkt_count_q + C_CNT_WIDTH'(1);
    end
  end

  assign keep_err  = keep_err_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_be_to_le_bridge.sv
// tb_be_to_le_bridge
//   Directed self-checking bench for be_to_le_bridge (DW=64, TW=128, CW=32).
module tb_be_to_le_bridge;
  import be_to_le_bridge_pkg::*;

  localparam int DW = 64;
  localparam int NB = 8;
  localparam int TW = 128;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] s_axis_tdata;
  logic [NB-1:0] s_axis_tkeep;
  logic [TW-1:0] s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [NB-1:0] m_axis_tkeep;
  logic [TW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [CW-1:0] pkt_count;
  logic          keep_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  be_to_le_bridge #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (TW),
    .C_CNT_WIDTH        (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_count     (pkt_count),
    .keep_err      (keep_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = '0;
    s_axis_tdata  = '0;
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    repeat (3) tick();
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b exp 0", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", m_axis_tvalid); end
    checks++; if ({m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== '0) begin errors++; $display("FAIL rst_payload got %h exp 0", m_axis_tdata); end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL rst_count got %h exp 0", pkt_count); end
    checks++; if (keep_err !== 1'b0) begin errors++; $display("FAIL rst_keep_err got %b exp 0", keep_err); end
    reset = 1'b0;
    tick();
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_release_tready got %b exp 1", s_axis_tready); end
  endtask

  task automatic test_single_beat();
    s_axis_tuser = 128'h0123456789ABCDEF_FEDCBA9876543210;
    drive(64'h0011223344556677, 8'hFF, 1'b1);
    tick();
    idle();
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL t1_valid got %b exp 1", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 64'h7766554433221100) begin errors++; $display("FAIL t1_data got %h exp 7766554433221100", m_axis_tdata); end
    checks++; if (m_axis_tkeep !== 8'hFF) begin errors++; $display("FAIL t1_keep got %h exp ff", m_axis_tkeep); end
    checks++; if (m_axis_tlast !== 1'b1) begin errors++; $display("FAIL t1_last got %b exp 1", m_axis_tlast); end
    checks++; if (m_axis_tuser !== 128'h0123456789ABCDEF_FEDCBA9876543210) begin errors++; $display("FAIL t1_user got %h exp 0123456789abcdeffedcba9876543210", m_axis_tuser); end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL t1_count got %0d exp 1", pkt_count); end
    checks++; if (keep_err !== 1'b0) begin errors++; $display("FAIL t1_keep_err got %b exp 0", keep_err); end
    tick();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t1_drained got %b exp 0", m_axis_tvalid); end
  endtask

  task automatic test_two_beat();
    drive(64'h0102030405060708, 8'hFF, 1'b0);
    tick();
    checks++; if (dut.state_q !== IN_PKT) begin errors++; $display("FAIL t2_state_mid got %0d exp IN_PKT", dut.state_q); end
    checks++; if (m_axis_tdata !== 64'h0807060504030201 || m_axis_tlast !== 1'b0) begin errors++; $display("FAIL t2_beat0 got %h/%b exp 0807060504030201/0", m_axis_tdata, m_axis_tlast); end
    drive(64'hAABBCCDDEEFF0011, 8'hE0, 1'b1);
    tick();
    idle();
    checks++; if (m_axis_tdata !== 64'h1100FFEEDDCCBBAA) begin errors++; $display("FAIL t2_data got %h exp 1100ffeeddccbbaa", m_axis_tdata); end
    checks++; if (m_axis_tkeep !== 8'h07) begin errors++; $display("FAIL t2_keep got %h exp 07", m_axis_tkeep); end
    checks++; if (m_axis_tlast !== 1'b1) begin errors++; $display("FAIL t2_last got %b exp 1", m_axis_tlast); end
    checks++; if (keep_err !== 1'b0) begin errors++; $display("FAIL t2_keep_err got %b exp 0", keep_err); end
    checks++; if (dut.state_q !== WAIT_SOP) begin errors++; $display("FAIL t2_state_end got %0d exp WAIT_SOP", dut.state_q); end
    checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL t2_count got %0d exp 2", pkt_count); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] in_d  [4];
    logic [DW-1:0] exp_d [4];
    logic          in_l  [4];
    int  sent;
    int  got;
    logic acc;
    logic saw_stall;
    in_d[0] = 64'hA0A1A2A3A4A5A6A7; exp_d[0] = 64'hA7A6A5A4A3A2A1A0; in_l[0] = 1'b0;
    in_d[1] = 64'hB0B1B2B3B4B5B6B7; exp_d[1] = 64'hB7B6B5B4B3B2B1B0; in_l[1] = 1'b0;
    in_d[2] = 64'hC0C1C2C3C4C5C6C7; exp_d[2] = 64'hC7C6C5C4C3C2C1C0; in_l[2] = 1'b0;
    in_d[3] = 64'hD0D1D2D3D4D5D6D7; exp_d[3] = 64'hD7D6D5D4D3D2D1D0; in_l[3] = 1'b1;
    sent = 0;
    got = 0;
    saw_stall = 1'b0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      m_axis_tready = !(cyc >= 1 && cyc <= 3);
      if (sent < 4) drive(in_d[sent], 8'hFF, in_l[sent]);
      else          idle();
      acc = s_axis_tvalid && s_axis_tready;
      if (sent == 2 && s_axis_tready == 1'b0) saw_stall = 1'b1;
      if (m_axis_tvalid && !m_axis_tready) begin
        checks++; if (m_axis_tdata !== exp_d[got]) begin errors++; $display("FAIL t3_hold[%0d] got %h exp %h", got, m_axis_tdata, exp_d[got]); end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++; if (m_axis_tdata !== exp_d[got] || m_axis_tlast !== in_l[got]) begin errors++; $display("FAIL t3_beat[%0d] got %h/%b exp %h/%b", got, m_axis_tdata, m_axis_tlast, exp_d[got], in_l[got]); end
        got++;
      end
      tick();
      if (acc) sent++;
    end
    idle();
    m_axis_tready = 1'b1;
    checks++; if (got != 4) begin errors++; $display("FAIL t3_delivered got %0d exp 4", got); end
    checks++; if (saw_stall !== 1'b1) begin errors++; $display("FAIL t3_tready_low got %b exp 1", saw_stall); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t3_no_dup got %b exp 0", m_axis_tvalid); end
    checks++; if (pkt_count !== 32'd3) begin errors++; $display("FAIL t3_count got %0d exp 3", pkt_count); end
  endtask

  task automatic test_keep_err();
    m_axis_tready = 1'b1;
    drive(64'h0123456789ABCDEF, 8'h7F, 1'b0);
    tick();
    checks++; if (keep_err !== 1'b1) begin errors++; $display("FAIL t4_err0 got %b exp 1", keep_err); end
    checks++; if (m_axis_tkeep !== 8'hFE || m_axis_tdata !== 64'hEFCDAB8967452301) begin errors++; $display("FAIL t4_beat0 got %h/%h exp fe/efcdab8967452301", m_axis_tkeep, m_axis_tdata); end
    drive(64'hFEDCBA9876543210, 8'hA0, 1'b1);
    tick();
    idle();
    checks++; if (keep_err !== 1'b1) begin errors++; $display("FAIL t4_err1 got %b exp 1", keep_err); end
    checks++; if (m_axis_tkeep !== 8'h05 || m_axis_tdata !== 64'h1032547698BADCFE || m_axis_tlast !== 1'b1) begin errors++; $display("FAIL t4_beat1 got %h/%h/%b exp 05/1032547698badcfe/1", m_axis_tkeep, m_axis_tdata, m_axis_tlast); end
    tick();
    checks++; if (keep_err !== 1'b0) begin errors++; $display("FAIL t4_pulse_end got %b exp 0", keep_err); end
    checks++; if (pkt_count !== 32'd4) begin errors++; $display("FAIL t4_count got %0d exp 4", pkt_count); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_count_q;
    checks++; if (pkt_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL t5_preload got %h exp ffffffff", pkt_count); end
    drive(64'h8899AABBCCDDEEFF, 8'hFF, 1'b1);
    tick();
    idle();
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL t5_wrap got %h exp 0", pkt_count); end
    checks++; if (m_axis_tdata !== 64'hFFEEDDCCBBAA9988) begin errors++; $display("FAIL t5_data got %h exp ffeeddccbbaa9988", m_axis_tdata); end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    drive(64'h1111111111111111, 8'hFF, 1'b0);
    tick();
    drive(64'h2222222222222222, 8'hFF, 1'b0);
    tick();
    reset = 1'b1;
    idle();
    tick();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t6_valid got %b exp 0", m_axis_tvalid); end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL t6_count got %0d exp 0", pkt_count); end
    checks++; if (dut.state_q !== WAIT_SOP) begin errors++; $display("FAIL t6_state got %0d exp WAIT_SOP", dut.state_q); end
    reset = 1'b0;
    tick();
    checks++; if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t6_after got %b/%b exp 1/0", s_axis_tready, m_axis_tvalid); end
    drive(64'h1122334455667788, 8'hF0, 1'b1);
    tick();
    idle();
    checks++; if (m_axis_tdata !== 64'h8877665544332211 || m_axis_tkeep !== 8'h0F) begin errors++; $display("FAIL t6_new_beat got %h/%h exp 8877665544332211/0f", m_axis_tdata, m_axis_tkeep); end
    checks++; if (keep_err !== 1'b0) begin errors++; $display("FAIL t6_keep_err got %b exp 0", keep_err); end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL t6_new_count got %0d exp 1", pkt_count); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_two_beat();
    test_backpressure();
    test_keep_err();
    test_wrap();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
